secded_decoder: RTL and testbench

Receive-side checker paired with the 64-bit single-bit-flip error generator on the encode/inject path. Takes a 72-bit Hamming SEC-DED codeword (64 data + 7 Hamming + 1 overall parity) over a valid/ready stream. Corrects any single-bit error and flags double-bit errors. Keeps saturating error statistics for the test harness.

---
 rtl/secded_pkg.sv | 30 +++
 rtl/secded_syndrome.sv | 21 ++
 rtl/secded_decoder.sv | 150 +++++++++++++++
 tb/tb_secded_decoder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// Shared constants, code layout map and result classes for the 72/64 SEC-DED
// encoder and decoder.
package secded_pkg;

    localparam int unsigned CODE_W = 72;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned SYN_W  = 7;

    typedef enum logic [1:0] {
        CLEAN,
        SEC,
        DED
    } secded_class_e;

    // Code position of data bit idx: the idx-th non-power-of-two position from 3 upward.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned n;
        data_pos = 0;
        n = 0;
        for (int unsigned p = 3; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) begin
                    data_pos = p;
                end
                n++;
            end
        end
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome (XOR of set-bit positions 1..71) and overall
// parity (XOR of all 72 bits) of a SEC-DED codeword.
module secded_syndrome
    import secded_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SYN_W-1:0]  syn,
    output logic              parity
);

    always_comb begin
        syn = '0;
        for (int unsigned i = 1; i < CODE_W; i++) begin
            if (code[i]) begin
                syn = syn ^ SYN_W'(i);
            end
        end
        parity = ^code;
    end

endmodule

// File: rtl/secded_decoder.sv
// Two-stage 72/64 SEC-DED decoder on valid/ready streams with saturating
// SEC/DED counters. Optional error log of the first DED word: SECDED_ERR_LOG_EN.
module secded_decoder
    import secded_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter bit          PASS_ON_DED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sec,
    output logic              out_ded,
    output logic [SYN_W-1:0]  out_pos,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
`ifdef SECDED_ERR_LOG_EN
    ,
    output logic              err_log_valid,
    output logic [CODE_W-1:0] err_log_code
`endif
);

    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [SYN_W-1:0]  s1_syn;
    logic              s1_par;

    logic [SYN_W-1:0]  in_syn;
    logic              in_par;
    logic              s1_advance;
    logic              s2_advance;
    logic              out_fire;

    secded_class_e     cls;
    logic [DATA_W-1:0] fixed_data;
    logic [DATA_W-1:0] next_data;

    secded_syndrome u_syndrome (
        .code   (in_code),
        .syn    (in_syn),
        .parity (in_par)
    );

    assign s2_advance = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_advance;
    assign in_ready   = !s1_valid || s1_advance;
    assign out_fire   = out_valid && out_ready;

    always_comb begin
        if (s1_syn == '0 && !s1_par) begin
            cls = CLEAN;
        end else if (s1_par && s1_syn <= SYN_W'(CODE_W - 1)) begin
            cls = SEC;
        end else begin
            cls = DED;
        end
    end

    // Correction is applied per data bit, so flips of check/parity bits fall out naturally.
    for (genvar i = 0; i < DATA_W; i++) begin : g_extract
        localparam int unsigned P = data_pos(i);
        assign fixed_data[i] = s1_code[P] ^ (cls == SEC && s1_syn == SYN_W'(P));
    end

    assign next_data = (cls == DED && !PASS_ON_DED) ? '0 : fixed_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= in_code;
                s1_syn  <= in_syn;
                s1_par  <= in_par;
            end
        end
    end

`ifdef SECDED_ERR_LOG_EN
    logic [CODE_W-1:0] s2_code;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sec   <= 1'b0;
            out_ded   <= 1'b0;
            out_pos   <= '0;
`ifdef SECDED_ERR_LOG_EN
            s2_code   <= '0;
`endif
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= next_data;
                out_sec  <= (cls == SEC);
                out_ded  <= (cls == DED);
                out_pos  <= (cls == SEC) ? s1_syn : '0;
`ifdef SECDED_ERR_LOG_EN
                s2_code  <= s1_code;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (out_fire && out_sec && corr_cnt != '1) begin
                corr_cnt <= corr_cnt + CNT_W'(1);
            end
            if (out_fire && out_ded && uncorr_cnt != '1) begin
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SECDED_ERR_LOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_log_valid <= 1'b0;
            err_log_code  <= '0;
        end else if (cnt_clr) begin
            err_log_valid <= 1'b0;
            err_log_code  <= '0;
        end else if (out_fire && out_ded && !err_log_valid) begin
            err_log_valid <= 1'b1;
            err_log_code  <= s2_code;
        end
    end
`endif

endmodule

// File: tb/tb_secded_decoder.sv
// Directed scoreboard bench for secded_decoder built with CNT_W=2 so counter
// saturation is reachable quickly.
`timescale 1ns/1ps
module tb_secded_decoder;

    localparam int unsigned TB_CNT_W = 2;
    localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;

    typedef struct packed {
        logic [63:0] data;
        logic        sec;
        logic        ded;
        logic [6:0]  pos;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [71:0]         in_code;
    logic                out_valid;
    logic                out_ready;
    logic [63:0]         out_data;
    logic                out_sec;
    logic                out_ded;
    logic [6:0]          out_pos;
    logic                cnt_clr;
    logic [TB_CNT_W-1:0] corr_cnt;
    logic [TB_CNT_W-1:0] uncorr_cnt;
`ifdef SECDED_ERR_LOG_EN
    logic                err_log_valid;
    logic [71:0]         err_log_code;
`endif

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_fail = 0;
    int   m_corr = 0;
    int   m_uncorr = 0;

    secded_decoder #(
        .CNT_W       (TB_CNT_W),
        .PASS_ON_DED (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sec    (out_sec),
        .out_ded    (out_ded),
        .out_pos    (out_pos),
        .cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
`ifdef SECDED_ERR_LOG_EN
        ,
        .err_log_valid (err_log_valid),
        .err_log_code  (err_log_code)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] encode(input logic [63:0] d);
        logic [71:0]  c;
        logic [6:0]   s;
        int unsigned  n;
        c = '0;
        n = 0;
        for (int unsigned p = 1; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[n];
                n++;
            end
        end
        s = '0;
        for (int unsigned p = 1; p < 72; p++) begin
            if (c[p]) s = s ^ 7'(p);
        end
        for (int unsigned k = 0; k < 7; k++) begin
            c[1 << k] = s[k];
        end
        c[0] = ^c[71:1];
        return c;
    endfunction

    function automatic logic [63:0] extract(input logic [71:0] c);
        logic [63:0] r;
        int unsigned n;
        r = '0;
        n = 0;
        for (int unsigned p = 1; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                r[n] = c[p];
                n++;
            end
        end
        return r;
    endfunction

    // Drive one word; expectation follows from how many bits were flipped, not from decoding.
    task automatic send_word(input logic [63:0] d, input int nf,
                             input int unsigned p1, input int unsigned p2, input int unsigned p3);
        logic [71:0] c;
        exp_t        e;
        bit          ok;
        c = encode(d);
        if (nf >= 1) c[p1] = ~c[p1];
        if (nf >= 2) c[p2] = ~c[p2];
        if (nf >= 3) c[p3] = ~c[p3];
        e.data = d;
        e.sec  = 1'b0;
        e.ded  = 1'b0;
        e.pos  = '0;
        if (nf == 1) begin
            e.sec = 1'b1;
            e.pos = 7'(p1);
        end else if (nf >= 2) begin
            e.ded  = 1'b1;
            e.data = extract(c);
        end
        in_valid = 1'b1;
        in_code  = c;
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("accept_timeout", 72'(ok), 72'(1'b1));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 60) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("drain_left", 72'(sb.size()), 72'(0));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_corr = 0;
            m_uncorr = 0;
        end else begin
            check("corr_cnt", 72'(corr_cnt), 72'(m_corr));
            check("uncorr_cnt", 72'(uncorr_cnt), 72'(m_uncorr));
            if (out_valid && out_ready) begin
                n_vec++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL spurious_out: observed data %h expected no output", out_data);
                end
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("out_data", 72'(out_data), 72'(mon_e.data));
                    check("out_sec", 72'(out_sec), 72'(mon_e.sec));
                    check("out_ded", 72'(out_ded), 72'(mon_e.ded));
                    check("out_pos", 72'(out_pos), 72'(mon_e.pos));
                    if (mon_e.sec && m_corr < CNT_MAX) m_corr++;
                    if (mon_e.ded && m_uncorr < CNT_MAX) m_uncorr++;
                end
            end
            if (cnt_clr) begin
                m_corr = 0;
                m_uncorr = 0;
            end
        end
    end

    initial begin
        logic [63:0] d;
        int          nf;
        int unsigned p1;
        int unsigned p2;

        rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_out_valid", 72'(out_valid), 72'(1'b0));
        check("rst_in_ready", 72'(in_ready), 72'(1'b1));
        check("rst_out_data", 72'(out_data), 72'(0));
        check("rst_flags", 72'({out_sec, out_ded, out_pos}), 72'(0));
        check("rst_counts", 72'({corr_cnt, uncorr_cnt}), 72'(0));

        // clean zero word, latency 2
        send_word(64'h0, 0, 0, 0, 0);
        check("lat_edge1_valid", 72'(out_valid), 72'(1'b0));
        @(posedge clk); #1;
        check("lat_edge2_valid", 72'(out_valid), 72'(1'b1));
        drain();

        send_word(64'h0, 1, 3, 0, 0);
        drain();
        check("corr_after_sec", 72'(corr_cnt), 72'(1));

        send_word(64'h0, 2, 3, 5, 0);
        drain();
        check("uncorr_after_ded", 72'(uncorr_cnt), 72'(1));

        send_word(64'h0, 1, 0, 0, 0);
        send_word(64'hDEAD_BEEF_0123_4567, 1, 64, 0, 0);
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 1, 71, 0, 0);
        send_word(64'h0F0F_0F0F_F0F0_F0F0, 3, 64, 8, 16);
        drain();

        // random stream at full throughput
        for (int i = 0; i < 10; i++) begin
            d  = {$urandom, $urandom};
            nf = $urandom_range(0, 2);
            p1 = $urandom_range(0, 71);
            p2 = (p1 + $urandom_range(1, 70)) % 72;
            check("thru_in_ready", 72'(in_ready), 72'(1'b1));
            send_word(d, nf, p1, p2, 0);
        end
        drain();

        // back-pressure: two words fill the pipe, third must wait
        out_ready = 1'b0;
        send_word(64'h1111_2222_3333_4444, 1, 9, 0, 0);
        send_word(64'h5555_6666_7777_8888, 0, 0, 0, 0);
        in_valid = 1'b1;
        in_code  = encode(64'h9999_AAAA_BBBB_CCCC);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 72'(in_ready), 72'(1'b0));
            check("bp_hold_data", 72'(out_data), 72'(sb[0].data));
            check("bp_hold_valid", 72'(out_valid), 72'(1'b1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        send_word(64'h9999_AAAA_BBBB_CCCC, 2, 1, 70, 0);
        send_word(64'hDDDD_EEEE_FFFF_0000, 1, 40, 0, 0);
        drain();

        // saturation at 3, then clear racing an increment
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_word({$urandom, $urandom}, 1, $urandom_range(0, 71), 0, 0);
        end
        drain();
        check("corr_saturated", 72'(corr_cnt), 72'(3));
        cnt_clr = 1'b1;
        send_word(64'h1234, 1, 5, 0, 0);
        drain();
        @(posedge clk); #1;
        check("corr_cleared", 72'(corr_cnt), 72'(0));
        cnt_clr = 1'b0;

        // reset with two words in flight
        send_word(64'hA5A5, 1, 7, 0, 0);
        send_word(64'h5A5A, 1, 11, 0, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 72'(out_valid), 72'(1'b0));
        check("midrst_in_ready", 72'(in_ready), 72'(1'b1));
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_word(64'hCAFE_F00D_0000_1111, 0, 0, 0, 0);
        check("post_rst_lat1", 72'(out_valid), 72'(1'b0));
        @(posedge clk); #1;
        check("post_rst_lat2", 72'(out_valid), 72'(1'b1));
        check("post_rst_data", 72'(out_data), 72'(64'hCAFE_F00D_0000_1111));
        drain();
        check("post_rst_counts", 72'({corr_cnt, uncorr_cnt}), 72'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
